// File: rtl/fsm_controller.sv
// Global sequencer for a ROWS x COLS systolic array:
// IDLE -> LOAD_X -> MAC (ROWS+COLS-1 cycles) -> STORE -> IDLE.
module fsm_controller #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int CYCLE_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [1:0]         global_state,
  output logic [CYCLE_W-1:0] cycle,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_X = 2'd1,
    S_MAC    = 2'd2,
    S_STORE  = 2'd3
  } state_e;

  // Last MAC cycle index: the wavefront needs ROWS+COLS-1 beats.
  localparam logic [CYCLE_W-1:0] MAC_LAST =
    CYCLE_W'(ROWS + COLS - 2);

  if (ROWS < 1 || ROWS > 16 ||
      COLS < 1 || COLS > 16 ||
      (2 ** CYCLE_W) <= (ROWS + COLS - 1)) begin : g_bad_cfg
    $error("fsm_controller: illegal ROWS/COLS/CYCLE_W");
  end

  state_e             state_q;
  state_e             state_d;
  logic [CYCLE_W-1:0] cycle_q;
  logic [CYCLE_W-1:0] cycle_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cycle_d = '0;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD_X;
      S_LOAD_X: state_d = S_MAC;
      S_MAC:    if (cycle_q == MAC_LAST) state_d = S_STORE;
      S_STORE:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_d == state_q && state_q != S_IDLE)
      cycle_d = cycle_q + CYCLE_W'(1);
  end

  assign global_state = state_q;
  assign cycle        = cycle_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_STORE);

endmodule

// File: tb/tb_fsm_controller.sv
// Bench for fsm_controller: vector table, corner sequences
// and random start/reset against a pass-position model.
module tb_fsm_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;

  logic [1:0] gs_a;
  logic [4:0] cyc_a;
  logic       busy_a;
  logic       done_a;
  logic [1:0] gs_b;
  logic [4:0] cyc_b;
  logic       busy_b;
  logic       done_b;

  int checks = 0;
  int errors = 0;

  fsm_controller #(.ROWS(4), .COLS(4), .CYCLE_W(5)) u_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .global_state (gs_a),
    .cycle        (cyc_a),
    .busy         (busy_a),
    .done         (done_a)
  );

  fsm_controller #(.ROWS(2), .COLS(3), .CYCLE_W(5)) u_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .global_state (gs_b),
    .cycle        (cyc_b),
    .busy         (busy_b),
    .done         (done_b)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act,
                     input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d",
               nm, act, expv);
    end
  endtask

  // Model: position within a pass, -1 when idle.
  // p=0 load, 1..n-1 mac (cycle p-1), p=n store; n=ROWS+COLS.
  localparam int NA = 8;
  localparam int NB = 5;
  int pa = -1;
  int pb = -1;

  function automatic int step(input int p, input int n,
                              input logic st);
    if (p < 0) return st ? 0 : -1;
    if (p == n) return -1;
    return p + 1;
  endfunction

  function automatic void expect_of(input int p, input int n,
                                    output int st,
                                    output int cyc);
    if (p < 0) begin st = 0; cyc = 0; end
    else if (p == 0) begin st = 1; cyc = 0; end
    else if (p < n) begin st = 2; cyc = p - 1; end
    else begin st = 3; cyc = 0; end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa = -1;
      pb = -1;
    end else begin
      pa = step(pa, NA, start);
      pb = step(pb, NB, start);
    end
  end

  logic rst_seen = 1'b0;
  int   ps_a = 0;
  int   ps_b = 0;

  always @(negedge rst_n) rst_seen = 1'b1;

  always @(negedge clk) begin
    int es, ec, ok;
    expect_of(pa, NA, es, ec);
    cmp("mdl_state_a", gs_a, es);
    cmp("mdl_cycle_a", cyc_a, ec);
    cmp("mdl_busy_a", busy_a, es != 0);
    cmp("mdl_done_a", done_a, es == 3);
    expect_of(pb, NB, es, ec);
    cmp("mdl_state_b", gs_b, es);
    cmp("mdl_cycle_b", cyc_b, ec);
    cmp("mdl_busy_b", busy_b, es != 0);
    cmp("mdl_done_b", done_b, es == 3);
    cmp("dec_busy_a", busy_a, gs_a != 2'd0);
    cmp("dec_done_a", done_a, gs_a == 2'd3);
    ok = (gs_a == ps_a) || (gs_a == (ps_a + 1) % 4) ||
         (gs_a == 0 && rst_seen);
    cmp("trans_a", ok, 1);
    ok = (gs_b == ps_b) || (gs_b == (ps_b + 1) % 4) ||
         (gs_b == 0 && rst_seen);
    cmp("trans_b", ok, 1);
    ps_a = gs_a;
    ps_b = gs_b;
    rst_seen = 1'b0;
  end

  typedef struct {
    logic rst_n;
    logic start;
    int   st;
    int   cyc;
    logic busy;
    logic done;
  } vec_t;

  vec_t vec[14];

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int lasta, lastb, na, nb, ba, bb, ma, mb, found;

    vec[0] = '{1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
    vec[1] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    vec[2] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    vec[3] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
    vec[4] = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++)
      vec[5+i] = '{1'b1, 1'b0, 2, i, 1'b1, 1'b0};
    vec[12] = '{1'b1, 1'b0, 3, 0, 1'b1, 1'b1};
    vec[13] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst_n = vec[i].rst_n;
      start = vec[i].start;
      @(posedge clk);
      #1;
      cmp($sformatf("vec%0d_state", i), gs_a, vec[i].st);
      cmp($sformatf("vec%0d_cycle", i), cyc_a, vec[i].cyc);
      cmp($sformatf("vec%0d_busy", i), busy_a, vec[i].busy);
      cmp($sformatf("vec%0d_done", i), done_a, vec[i].done);
    end

    // Single pass: pass length and MAC length per geometry.
    do_reset();
    ba = 0; bb = 0; ma = 0; mb = 0;
    for (int k = 0; k < 14; k++) begin
      start = (k == 0);
      @(posedge clk);
      #1;
      ba += busy_a;
      bb += busy_b;
      ma += (gs_a == 2'd2);
      mb += (gs_b == 2'd2);
    end
    cmp("pass_len_a", ba, 9);
    cmp("mac_len_a", ma, 7);
    cmp("pass_len_b", bb, 6);
    cmp("mac_len_b", mb, 4);

    // Held start: STORE-to-STORE spacing is pass + 1 idle.
    do_reset();
    start = 1'b1;
    lasta = -1; lastb = -1; na = 0; nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        if (lasta >= 0) cmp("hold_gap_a", k - lasta, 10);
        lasta = k;
        na++;
      end
      if (done_b) begin
        if (lastb >= 0) cmp("hold_gap_b", k - lastb, 7);
        lastb = k;
        nb++;
      end
    end
    cmp("hold_passes_a", na >= 3, 1);
    cmp("hold_passes_b", nb >= 5, 1);

    // Reset mid-MAC aborts the pass with no done.
    do_reset();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (gs_a == 2'd2 && cyc_a == 5'd3) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    cmp("mac3_reached", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("abort_state", gs_a, 0);
    cmp("abort_cycle", cyc_a, 0);
    cmp("abort_busy", busy_a, 0);
    cmp("abort_done", done_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    na = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      na += done_a;
    end
    cmp("abort_no_done", na, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cmp("restart_load", gs_a, 1);

    // Random start and occasional reset vs. the model.
    for (int k = 0; k < 400; k++) begin
      start = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 60) != 0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_controller.md
FSM_CONTROLLER -- requirements
Module: fsm_controller

Interface
REQ-001 Parameter ROWS, default 4, systolic array row count; legal range 1..16.
REQ-002 Parameter COLS, default 4, systolic array column count; legal range 1..16.
REQ-003 Parameter CYCLE_W, default 5, width of the cycle counter; SHALL satisfy 2^CYCLE_W > ROWS+COLS-1.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  level-sampled request to run one compute pass.
REQ-007 global_state  output  2  current state: 0=S_IDLE, 1=S_LOAD_X, 2=S_MAC, 3=S_STORE.
REQ-008 cycle  output  CYCLE_W  cycles elapsed in the current state; 0 on the first cycle of each state.
REQ-009 busy  output  1  high whenever global_state != S_IDLE.
REQ-010 done  output  1  high for exactly the one S_STORE cycle of each pass.

Function
REQ-011 The state register SHALL be 2 bits; global_state SHALL be driven directly from it, with no combinational path from start.
REQ-012 S_IDLE: if start=1 at a rising edge, the next state SHALL be S_LOAD_X; otherwise it SHALL remain S_IDLE.
REQ-013 S_LOAD_X SHALL last exactly 1 cycle, then go to S_MAC.
REQ-014 S_MAC SHALL last exactly ROWS+COLS-1 cycles, with cycle counting 0..ROWS+COLS-2, then go to S_STORE.
REQ-015 S_STORE SHALL last exactly 1 cycle, then go to S_IDLE.
REQ-016 A pass SHALL occupy ROWS+COLS+1 cycles from S_LOAD_X entry to S_IDLE re-entry (9 cycles for 4x4).
REQ-017 start SHALL be ignored in every state except S_IDLE; a held start re-triggers only from S_IDLE.
REQ-018 If start is still 1 in the first S_IDLE cycle after S_STORE, a new pass SHALL begin, giving 1 IDLE cycle between passes.
REQ-019 cycle SHALL reset to 0 on every state transition, increment by 1 each cycle within a state, and hold at 0 in S_IDLE.
REQ-020 cycle SHALL never wrap within a legal configuration.
REQ-021 busy and done SHALL be pure decodes of the state register, glitch-free with respect to start.
REQ-022 State encodings 0..3 are fixed; no illegal states exist.

Reset
REQ-023 While rst_n=0, and immediately on its falling edge: global_state=0 (S_IDLE), cycle=0, busy=0, done=0.
REQ-024 Reset asserted mid-pass (any state) SHALL abort the pass immediately, with no further done pulse for it.
REQ-025 After rst_n rises, the first start sampled at a rising edge SHALL start a pass normally.

Verification
REQ-026 Reset, then hold rst_n=1 with start=0 for 3 cycles -> global_state=0, cycle=0, busy=0, done=0 throughout.
REQ-027 4x4 pass: start=1 for one edge -> LOAD_X for 1 cycle, MAC for 7 cycles (cycle 0..6), STORE for 1 cycle with done=1, then IDLE; all complete within 14 edges.
REQ-028 Start held high continuously -> passes repeat with exactly 1 IDLE cycle between consecutive STORE cycles; start pulses during MAC have no effect.
REQ-029 rst_n driven low during MAC at cycle=3 -> asynchronous return to global_state=0, cycle=0, done=0 with no pending done.
REQ-030 ROWS=2, COLS=3 -> MAC lasts exactly 4 cycles and the total pass is 6 cycles.
REQ-031 Assertions: busy == (global_state!=0); done == (global_state==3); the state sequence only ever follows 0->1->2->3->0.
